// File: rtl/loader_pkg.sv
// Shared types and defaults for the loader-to-RAM bridge: bridge states,
// the buffered write entry and default geometry.
package loader_pkg;

   localparam int LDR_DATA_W    = 8;
   localparam int LDR_ADDR_W    = 16;
   localparam int LDR_DEPTH     = 4;
   localparam int LDR_WR_CYCLES = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSREQ = 2'd1,
      ST_WRITE  = 2'd2,
      ST_HOLD   = 2'd3
   } bridge_state_e;

   typedef struct packed {
      logic [LDR_ADDR_W-1:0] addr;
      logic [LDR_DATA_W-1:0] data;
   } wr_entry_t;

endpackage

// File: rtl/loader_fifo.sv
// Synchronous FIFO of write entries. A push while full is refused; count_nxt
// exposes the post-edge occupancy so callers can register flags against it.
module loader_fifo
   import loader_pkg::*;
#(
   parameter type entry_t = wr_entry_t,
   parameter int  DEPTH   = LDR_DEPTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  entry_t                 wr_entry,
   input  logic                   pop,
   output entry_t                 head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic [$clog2(DEPTH):0] count_nxt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // NOTE: give every always_comb output a default first so no path leaves it unassigned (that would infer a latch).
   always_comb begin
      count_nxt = count;
      if (do_push && !do_pop)
         count_nxt = count + CNT_W'(1);
      else if (!do_push && do_pop)
         count_nxt = count - CNT_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_nxt;
      end
   end

   // NOTE: storage is not reset; the cleared pointers/count already mark every entry invalid.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wr_entry;
   end

endmodule

// File: rtl/loader_ram_bridge.sv
// Buffers loader byte writes, takes the Z80 bus via BUSRQ/BUSAK, drains them into
// RAM and defers the execute jump. Define LOADER_CHECKSUM_EN to add a checksum output.
module loader_ram_bridge
   import loader_pkg::*;
#(
   parameter int DATA      = LDR_DATA_W,
   parameter int ADDR      = LDR_ADDR_W,
   parameter int DEPTH     = LDR_DEPTH,
   parameter int WR_CYCLES = LDR_WR_CYCLES
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            loader_download,
   input  logic            loader_wr,
   input  logic [ADDR-1:0] loader_addr,
   input  logic [DATA-1:0] loader_data,
   input  logic [ADDR-1:0] execute_addr,
   input  logic            execute_enable,
   output logic            loader_wait,
   output logic            cpu_busrq,
   input  logic            cpu_busak,
   output logic [ADDR-1:0] ram_addr,
   output logic [DATA-1:0] ram_dout,
   output logic            ram_we,
   output logic            exec_req,
   output logic [ADDR-1:0] exec_addr,
   input  logic            exec_ack,
   output logic            overflow,
   output logic            busy
`ifdef LOADER_CHECKSUM_EN
   ,
   output logic [7:0]      checksum
`endif
);

   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int BEAT_W = $clog2(WR_CYCLES + 1);

   localparam logic [1:0] IDLE   = ST_IDLE;
   localparam logic [1:0] BUSREQ = ST_BUSREQ;
   localparam logic [1:0] WRITE  = ST_WRITE;
   localparam logic [1:0] HOLD   = ST_HOLD;

   typedef struct packed {
      logic [ADDR-1:0] addr;
      logic [DATA-1:0] data;
   } entry_t;

   logic [1:0]        state;
   logic [BEAT_W-1:0] beat;
   logic              dl_q;
   logic              dl_rise;
   logic              pending;
   logic              last_beat;

   entry_t            wr_entry;
   entry_t            fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W-1:0]  fifo_count_nxt;

   assign wr_entry  = '{addr: loader_addr, data: loader_data};
   assign last_beat = (state == WRITE) && (beat == BEAT_W'(WR_CYCLES - 1));
   assign dl_rise   = loader_download && !dl_q;

   loader_fifo #(
      .entry_t (entry_t),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (loader_wr),
      .wr_entry  (wr_entry),
      .pop       (last_beat),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .count_nxt (fifo_count_nxt)
   );

   // Outputs decode straight from the state register, so reset drops them on the same edge.
   assign cpu_busrq = (state != IDLE);
   assign ram_we    = (state == WRITE);
   assign ram_addr  = ram_we ? fifo_head.addr : '0;
   assign ram_dout  = ram_we ? fifo_head.data : '0;
   assign busy      = !fifo_empty || (state != IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         beat  <= '0;
      end else begin
         case (state)
            IDLE:
               if (!fifo_empty) state <= BUSREQ;
            BUSREQ:
               if (cpu_busak) begin
                  state <= WRITE;
                  beat  <= '0;
               end
            // The bus is not re-checked mid-beat: BUSAK cannot drop while BUSRQ is held.
            WRITE:
               if (last_beat) begin
                  beat <= '0;
                  if (fifo_count_nxt == '0) state <= HOLD;
               end else begin
                  beat <= beat + BEAT_W'(1);
               end
            HOLD:
               if (!fifo_empty) begin
                  state <= WRITE;
                  beat  <= '0;
               end else if (!loader_download) begin
                  state <= IDLE;
               end
            default:
               state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         dl_q        <= 1'b0;
         loader_wait <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         dl_q        <= loader_download;
         loader_wait <= (fifo_count_nxt >= CNT_W'(DEPTH - 1));
         if (dl_rise)
            overflow <= 1'b0;
         if (loader_wr && fifo_full)
            overflow <= 1'b1;
      end
   end

   // The jump is offered only once the bus is released and every byte has landed.
   always_ff @(posedge clock) begin
      if (reset) begin
         pending   <= 1'b0;
         exec_req  <= 1'b0;
         exec_addr <= '0;
      end else begin
         if (exec_req && exec_ack) begin
            pending  <= 1'b0;
            exec_req <= 1'b0;
         end else begin
            exec_req <= pending && (state == IDLE) && (fifo_count == '0) && !loader_download;
         end
         if (execute_enable) begin
            pending   <= 1'b1;
            exec_addr <= execute_addr;
         end
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clock) begin
      if (reset)
         checksum <= '0;
      else if (dl_rise)
         checksum <= '0;
      else if (last_beat)
         checksum <= checksum + 8'(fifo_head.data);
   end
`endif

endmodule
